// File: rtl/v35_intc_regs_pkg.sv
// v35_intc_regs_pkg: shared SFR offsets, EXIC layout and helpers for the
// V35 interrupt register block.
// Optional build macro: V35_INTP_FILTER_EN (pin noise filter in v35_pin_detect).
package v35_intc_regs_pkg;

    // SFR offsets relative to SFR_BASE
    localparam logic [7:0] SFR_INTM  = 8'h00;
    localparam logic [7:0] SFR_EXIC0 = 8'h0C;
    localparam logic [7:0] SFR_EXIC1 = 8'h0D;
    localparam logic [7:0] SFR_EXIC2 = 8'h0E;

    // EXIC bit positions
    localparam int EXIF_BIT = 7;
    localparam int EXMK_BIT = 6;
    localparam int EXPR_LSB = 0;

    localparam logic [7:0] EXIC_RESET = 8'h47;

    // Noise filter reload value: a level must differ for FLT_LOAD+1 samples
    localparam logic [1:0] FLT_LOAD = 2'd3;

    typedef struct packed {
        logic       exif;
        logic       exmk;
        logic [2:0] rsvd;
        logic [2:0] prio;
    } exic_t;

    // Next EXIC value: edge trigger beats clear, clear beats SFR write, so a
    // request arriving together with an acknowledge or a write is never lost.
    function automatic exic_t exic_next(input exic_t cur, input logic trig,
                                        input logic clr, input logic wr,
                                        input logic [7:0] din);
        logic [7:0] nxt;
        nxt = wr ? din : cur;
        if (trig)
            nxt[EXIF_BIT] = 1'b1;
        else if (clr)
            nxt[EXIF_BIT] = 1'b0;
        return exic_t'(nxt);
    endfunction

endpackage

// File: rtl/v35_intc_regs_pin_detect.sv
// v35_pin_detect: per-pin synchroniser, optional noise filter, previous-level
// flop and direction-selected edge trigger. All state advances on i_ce only.
// Optional build macro: V35_INTP_FILTER_EN adds a 4-sample majority-free
// stability filter (the filtered level doubles as the previous level).
module v35_pin_detect
    import v35_intc_regs_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ce,
    input  logic i_pin,
    input  logic i_dir,
    output logic o_trig
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync_out;
    logic                   w_lvl;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_sync <= '0;
        else if (i_ce)
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end

`ifdef V35_INTP_FILTER_EN
    logic [1:0] r_flt_cnt;
    logic       w_differ;

    assign w_differ = w_sync_out ^ r_prev;
    assign w_lvl    = (w_differ && (r_flt_cnt == 2'd0)) ? w_sync_out : r_prev;

    // Down-count consecutive differing samples; reload on agreement or accept
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_flt_cnt <= FLT_LOAD;
        else if (i_ce) begin
            if (!w_differ || (r_flt_cnt == 2'd0))
                r_flt_cnt <= FLT_LOAD;
            else
                r_flt_cnt <= r_flt_cnt - 2'd1;
        end
    end
`else
    assign w_lvl = w_sync_out;
`endif

    // Remember the last accepted level for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_prev <= 1'b0;
        else if (i_ce)
            r_prev <= w_lvl;
    end

    // A change fires only when the new level matches the programmed direction
    assign o_trig = i_ce & (w_lvl ^ r_prev) & (r_prev ^ i_dir);

endmodule

// File: rtl/v35_intc_regs.sv
// v35_intc_regs: owns EXIC0..2 and INTM, detects NMI/INTP edges, keeps the
// NMI pending latch and EXIF request flags for the priority controller.
// Optional build macro: V35_INTP_FILTER_EN (passed down to v35_pin_detect).
module v35_intc_regs
    import v35_intc_regs_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] SFR_BASE    = 8'h40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       NMI_PIN,
    input  logic [2:0] INTP,
    input  logic [7:0] sfr_addr,
    input  logic       sfr_wr,
    input  logic       sfr_rd,
    input  logic [7:0] sfr_din,
    output logic [7:0] sfr_dout,
    output logic       NMI,
    output logic [7:0] EXIC0,
    output logic [7:0] EXIC1,
    output logic [7:0] EXIC2,
    input  logic       NMI_clear,
    input  logic       EXIC0_clear,
    input  logic       EXIC1_clear,
    input  logic       EXIC2_clear,
    output logic [7:0] INTM_out
);

    localparam logic [7:0] A_INTM  = SFR_BASE + SFR_INTM;
    localparam logic [7:0] A_EXIC0 = SFR_BASE + SFR_EXIC0;
    localparam logic [7:0] A_EXIC1 = SFR_BASE + SFR_EXIC1;
    localparam logic [7:0] A_EXIC2 = SFR_BASE + SFR_EXIC2;

    // Index 0 is NMI, 1..3 are INTP0..2 throughout
    logic [3:0] w_pin;
    logic [3:0] w_trig;
    logic [3:0] w_clr_pulse;
    logic [3:0] w_clr;
    logic [2:0] w_wr_exic;
    logic       w_wr_intm;
    logic [7:0] w_rd_data;

    logic [3:0] r_intm;
    logic [3:0] r_clr_pend;
    logic       r_nmi;
    exic_t      r_exic [3];
    logic [7:0] r_dout;

    assign w_pin       = {INTP, NMI_PIN};
    assign w_clr_pulse = {EXIC2_clear, EXIC1_clear, EXIC0_clear, NMI_clear};
    assign w_clr       = w_clr_pulse | r_clr_pend;

    assign w_wr_intm    = ce & sfr_wr & (sfr_addr == A_INTM);
    assign w_wr_exic[0] = ce & sfr_wr & (sfr_addr == A_EXIC0);
    assign w_wr_exic[1] = ce & sfr_wr & (sfr_addr == A_EXIC1);
    assign w_wr_exic[2] = ce & sfr_wr & (sfr_addr == A_EXIC2);

    for (genvar g = 0; g < 4; g++) begin : g_pin
        v35_pin_detect #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_pin (
            .i_clk (clk),
            .i_rst (reset),
            .i_ce  (ce),
            .i_pin (w_pin[g]),
            .i_dir (r_intm[g]),
            .o_trig(w_trig[g])
        );
    end

    // Acknowledge pulses arriving while ce=0 are held until the next ce
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_clr_pend <= '0;
        else if (ce)
            r_clr_pend <= '0;
        else
            r_clr_pend <= r_clr_pend | w_clr_pulse;
    end

    // INTM edge-direction register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_intm <= '0;
        else if (w_wr_intm)
            r_intm <= sfr_din[3:0];
    end

    // NMI pending latch: set by edge, cleared by acknowledge, edge wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_nmi <= 1'b0;
        else if (ce)
            r_nmi <= w_trig[0] | (~w_clr[0] & r_nmi);
    end

    // EXIC request/config registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++)
                r_exic[k] <= exic_t'(EXIC_RESET);
        end else if (ce) begin
            for (int k = 0; k < 3; k++)
                r_exic[k] <= exic_next(r_exic[k], w_trig[k+1], w_clr[k+1],
                                       w_wr_exic[k], sfr_din);
        end
    end

    // Read-data decode of the current (pre-write) register contents
    always_comb begin
        w_rd_data = 8'h00;
        case (sfr_addr)
            A_INTM:  w_rd_data = {4'h0, r_intm};
            A_EXIC0: w_rd_data = r_exic[0];
            A_EXIC1: w_rd_data = r_exic[1];
            A_EXIC2: w_rd_data = r_exic[2];
            default: w_rd_data = 8'h00;
        endcase
    end

    // Registered read port, holds between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_dout <= 8'h00;
        else if (ce && sfr_rd)
            r_dout <= w_rd_data;
    end

    assign sfr_dout = r_dout;
    assign NMI      = r_nmi;
    assign EXIC0    = r_exic[0];
    assign EXIC1    = r_exic[1];
    assign EXIC2    = r_exic[2];
    assign INTM_out = {4'h0, r_intm};

endmodule

// File: tb/tb_v35_intc_regs.sv
// Testbench for v35_intc_regs: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a behavioural reference model.
module tb_v35_intc_regs;

    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] SFR_BASE    = 8'h40;
`ifdef V35_INTP_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LAT = FILT ? SYNC_STAGES + 4 : SYNC_STAGES + 1;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       NMI_PIN;
    logic [2:0] INTP;
    logic [7:0] sfr_addr;
    logic       sfr_wr;
    logic       sfr_rd;
    logic [7:0] sfr_din;
    logic [7:0] sfr_dout;
    logic       NMI;
    logic [7:0] EXIC0, EXIC1, EXIC2;
    logic       NMI_clear, EXIC0_clear, EXIC1_clear, EXIC2_clear;
    logic [7:0] INTM_out;
    logic       chk_req;

    v35_intc_regs #(
        .SYNC_STAGES(SYNC_STAGES),
        .SFR_BASE   (SFR_BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .NMI_PIN    (NMI_PIN),
        .INTP       (INTP),
        .sfr_addr   (sfr_addr),
        .sfr_wr     (sfr_wr),
        .sfr_rd     (sfr_rd),
        .sfr_din    (sfr_din),
        .sfr_dout   (sfr_dout),
        .NMI        (NMI),
        .EXIC0      (EXIC0),
        .EXIC1      (EXIC1),
        .EXIC2      (EXIC2),
        .NMI_clear  (NMI_clear),
        .EXIC0_clear(EXIC0_clear),
        .EXIC1_clear(EXIC1_clear),
        .EXIC2_clear(EXIC2_clear),
        .INTM_out   (INTM_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int phase   = 0;

    typedef struct {
        logic [7:0] dout;
        logic       nmi;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] intm;
        int         ph;
    } exp_t;

    exp_t sb[$];

    // Reference model: register contents plus per-pin history of ce samples
    logic [7:0] m_exic [3];
    logic [3:0] m_intm;
    logic       m_nmi;
    logic [7:0] m_dout;
    logic [3:0] m_pend;
    logic       m_hist [4][8];
    logic       m_filt [4];

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (phase %0d): got %02h, want %02h", name, phase, act, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a == SFR_BASE)                return {4'h0, m_intm};
        if (a == 8'(SFR_BASE + 8'h0C))    return m_exic[0];
        if (a == 8'(SFR_BASE + 8'h0D))    return m_exic[1];
        if (a == 8'(SFR_BASE + 8'h0E))    return m_exic[2];
        return 8'h00;
    endfunction

    // One clock: predict, queue expectation if observed, clock, commit
    task automatic cycle();
        logic [7:0] n_exic [3];
        logic [3:0] n_intm, n_pend, pulses, pins, trig, clr;
        logic       n_nmi;
        logic [7:0] n_dout;
        logic       nh [4][8];
        logic       nf [4];
        logic       all_diff, wr;
        exp_t       e;

        pins   = {INTP, NMI_PIN};
        pulses = {EXIC2_clear, EXIC1_clear, EXIC0_clear, NMI_clear};
        n_exic = m_exic;
        n_intm = m_intm;
        n_nmi  = m_nmi;
        n_dout = m_dout;
        n_pend = m_pend;
        nh     = m_hist;
        nf     = m_filt;
        trig   = '0;
        clr    = '0;

        if (reset) begin
            for (int k = 0; k < 3; k++) n_exic[k] = 8'h47;
            n_intm = '0; n_nmi = 1'b0; n_dout = 8'h00; n_pend = '0;
            for (int p = 0; p < 4; p++) begin
                nf[p] = 1'b0;
                for (int a = 0; a < 8; a++) nh[p][a] = 1'b0;
            end
        end else if (!ce) begin
            n_pend = m_pend | pulses;
        end else begin
            n_pend = '0;
            clr    = pulses | m_pend;
            for (int p = 0; p < 4; p++) begin
                for (int a = 7; a > 0; a--) nh[p][a] = m_hist[p][a-1];
                nh[p][0] = pins[p];
                if (FILT) begin
                    all_diff = 1'b1;
                    for (int a = SYNC_STAGES; a < SYNC_STAGES + 4; a++)
                        if (nh[p][a] == m_filt[p]) all_diff = 1'b0;
                    if (all_diff) begin
                        nf[p]   = nh[p][SYNC_STAGES];
                        trig[p] = (nf[p] == m_intm[p]);
                    end
                end else begin
                    trig[p] = (nh[p][SYNC_STAGES] != nh[p][SYNC_STAGES+1]) &&
                              (nh[p][SYNC_STAGES] == m_intm[p]);
                end
            end
            if (sfr_rd) n_dout = m_read(sfr_addr);
            if (sfr_wr && sfr_addr == SFR_BASE) n_intm = sfr_din[3:0];
            for (int k = 0; k < 3; k++) begin
                wr = sfr_wr && (sfr_addr == 8'(SFR_BASE + 8'h0C + k));
                if (wr) n_exic[k][6:0] = sfr_din[6:0];
                if (trig[k+1])      n_exic[k][7] = 1'b1;
                else if (clr[k+1])  n_exic[k][7] = 1'b0;
                else if (wr)        n_exic[k][7] = sfr_din[7];
            end
            if (trig[0])      n_nmi = 1'b1;
            else if (clr[0])  n_nmi = 1'b0;
        end

        if (chk_req || (ce && sfr_rd)) begin
            e.dout = n_dout; e.nmi = n_nmi; e.e0 = n_exic[0]; e.e1 = n_exic[1];
            e.e2 = n_exic[2]; e.intm = {4'h0, n_intm}; e.ph = phase;
            sb.push_back(e);
        end

        @(posedge clk);
        m_exic = n_exic; m_intm = n_intm; m_nmi = n_nmi; m_dout = n_dout;
        m_pend = n_pend; m_hist = nh; m_filt = nf;
        @(negedge clk);
    endtask

    // Monitor: whenever the DUT presents read data (or a check is requested)
    initial begin
        logic pend;
        exp_t e;
        forever begin
            @(posedge clk);
            pend = chk_req | (ce & sfr_rd);
            @(negedge clk);
            if (pend) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_empty (phase %0d): got no entry, want one", phase);
                end else begin
                    e = sb.pop_front();
                    cmp("sfr_dout", sfr_dout, e.dout);
                    cmp("nmi",      {7'h0, NMI}, {7'h0, e.nmi});
                    cmp("exic0",    EXIC0, e.e0);
                    cmp("exic1",    EXIC1, e.e1);
                    cmp("exic2",    EXIC2, e.e2);
                    cmp("intm",     INTM_out, e.intm);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        sfr_wr = 1'b1; sfr_addr = a; sfr_din = d;
        cycle();
        sfr_wr = 1'b0;
    endtask

    task automatic sfr_read(input logic [7:0] a);
        sfr_rd = 1'b1; sfr_addr = a;
        cycle();
        sfr_rd = 1'b0;
    endtask

    task automatic ce_group();
        ce = 1'b0; cycle(); cycle();
        ce = 1'b1; cycle();
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; NMI_PIN = 1'b0; INTP = '0;
        sfr_addr = '0; sfr_wr = 1'b0; sfr_rd = 1'b0; sfr_din = '0;
        NMI_clear = 1'b0; EXIC0_clear = 1'b0; EXIC1_clear = 1'b0; EXIC2_clear = 1'b0;
        chk_req = 1'b0;

        // 1: reset mid-stream
        phase = 1;
        @(negedge clk);
        chk_req = 1'b1; cycle(); chk_req = 1'b0;
        reset = 1'b0;
        sfr_write(8'h4C, 8'h12);
        sfr_write(8'h40, 8'h0F);
        INTP = 3'b101; NMI_PIN = 1'b1;
        repeat (LAT + 1) cycle();
        reset = 1'b1; chk_req = 1'b1; cycle();
        INTP = '0; NMI_PIN = 1'b0; cycle(); chk_req = 1'b0;
        reset = 1'b0;
        chk_req = 1'b1; cycle(); chk_req = 1'b0;
        cmp("rst_dout", sfr_dout, 8'h00);
        sfr_read(8'h4C); cmp("rst_exic0", sfr_dout, 8'h47);
        sfr_read(8'h4D); cmp("rst_exic1", sfr_dout, 8'h47);
        sfr_read(8'h4E); cmp("rst_exic2", sfr_dout, 8'h47);
        sfr_read(8'h40); cmp("rst_intm",  sfr_dout, 8'h00);
        cmp("rst_nmi", {7'h0, NMI}, 8'h00);

        // 2: rising INTP1, exact latency, falling edge ignored
        phase = 2;
        sfr_write(8'h40, 8'h04);
        chk_req = 1'b1;
        INTP[1] = 1'b1;
        repeat (LAT - 1) cycle();
        cmp("intp1_early", EXIC1, 8'h47);
        cycle();
        cmp("intp1_set", EXIC1, 8'hC7);
        EXIC1_clear = 1'b1; cycle(); EXIC1_clear = 1'b0;
        cmp("intp1_clr", EXIC1, 8'h47);
        INTP[1] = 1'b0;
        repeat (LAT + 2) cycle();
        cmp("intp1_fall", EXIC1, 8'h47);

        // 3: falling NMI
        phase = 3;
        NMI_PIN = 1'b1;
        repeat (LAT + 1) cycle();
        cmp("nmi_rise_ign", {7'h0, NMI}, 8'h00);
        NMI_PIN = 1'b0;
        repeat (LAT) cycle();
        cmp("nmi_set", {7'h0, NMI}, 8'h01);
        repeat (3) cycle();
        cmp("nmi_hold", {7'h0, NMI}, 8'h01);
        NMI_clear = 1'b1; cycle(); NMI_clear = 1'b0;
        cmp("nmi_clr", {7'h0, NMI}, 8'h00);

        // 4: collisions on EXIC0
        phase = 4;
        sfr_write(8'h40, 8'h06);
        sfr_write(8'h4C, 8'hC7);
        INTP[0] = 1'b1;
        repeat (LAT - 1) cycle();
        EXIC0_clear = 1'b1; cycle(); EXIC0_clear = 1'b0;
        cmp("clr_vs_trig", EXIC0, 8'hC7);
        EXIC0_clear = 1'b1; cycle(); EXIC0_clear = 1'b0;
        cmp("clr_only", EXIC0, 8'h47);
        INTP[0] = 1'b0;
        repeat (LAT + 2) cycle();
        INTP[0] = 1'b1;
        repeat (LAT - 1) cycle();
        sfr_write(8'h4C, 8'h05);
        cmp("wr_vs_trig", EXIC0, 8'h85);

        // 5: ce gating
        phase = 5;
        sfr_write(8'h40, 8'h0E);
        sfr_write(8'h4E, 8'hC7);
        ce = 1'b0;
        EXIC2_clear = 1'b1; cycle(); EXIC2_clear = 1'b0;
        cycle();
        cmp("ce0_hold", EXIC2, 8'hC7);
        ce = 1'b1; cycle();
        cmp("ce_clr", EXIC2, 8'h47);
        INTP[2] = 1'b1;
        repeat (LAT - 1) ce_group();
        cmp("ce_lat_early", EXIC2, 8'h47);
        ce_group();
        cmp("ce_lat_set", EXIC2, 8'hC7);

        // 6: short INTP0 glitch
        phase = 6;
        EXIC0_clear = 1'b1; cycle(); EXIC0_clear = 1'b0;
        INTP[0] = 1'b0;
        repeat (LAT + 3) cycle();
        cmp("glitch_pre", EXIC0, 8'h05);
        INTP[0] = 1'b1; cycle(); cycle();
        INTP[0] = 1'b0;
        repeat (LAT + 4) cycle();
        cmp("glitch", EXIC0, FILT ? 8'h05 : 8'h85);
        chk_req = 1'b0;

        // 7: randomized traffic
        phase = 7;
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] addrs [5];
            addrs[0] = 8'h40; addrs[1] = 8'h4C; addrs[2] = 8'h4D; addrs[3] = 8'h4E;
            addrs[4] = 8'($urandom);
            reset       = ($urandom_range(0, 299) == 0);
            ce          = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) NMI_PIN = ~NMI_PIN;
            for (int p = 0; p < 3; p++)
                if ($urandom_range(0, 7) == 0) INTP[p] = ~INTP[p];
            sfr_wr      = ($urandom_range(0, 5) == 0);
            sfr_rd      = ($urandom_range(0, 3) == 0);
            sfr_addr    = addrs[$urandom_range(0, 4)];
            sfr_din     = 8'($urandom);
            NMI_clear   = ($urandom_range(0, 9) == 0);
            EXIC0_clear = ($urandom_range(0, 9) == 0);
            EXIC1_clear = ($urandom_range(0, 9) == 0);
            EXIC2_clear = ($urandom_range(0, 9) == 0);
            chk_req     = ($urandom_range(0, 2) == 0);
            cycle();
        end

        reset = 1'b0; ce = 1'b1; sfr_wr = 1'b0; sfr_rd = 1'b0; chk_req = 1'b0;
        NMI_clear = 1'b0; EXIC0_clear = 1'b0; EXIC1_clear = 1'b0; EXIC2_clear = 1'b0;
        repeat (4) cycle();
        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_drain: got %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/v35_intc_regs.md
Name: v35_intc_regs

Overview:
- SFR-side controller that owns the V35 interrupt configuration and request state, and feeds the priority controller.
- Holds EXIC0/1/2 and INTM.
- Synchronises and edge-detects the NMI and INTP0..2 pins.
- Sets request flags (EXIF) and the NMI pending latch; clears them on the controller's acknowledge pulses.
- Sits between the CPU SFR bus, the external pins and v35_pic.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per pin (legal 2..3).
- SFR_BASE, 8'h40, SFR offset of INTM; EXICn at SFR_BASE+8'h0C+n.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; all state advances only when ce=1
- NMI_PIN  in  1  raw NMI pin
- INTP  in  3  raw INTP0..2 pins
- sfr_addr  in  8  SFR offset
- sfr_wr  in  1  write strobe, sampled with ce
- sfr_rd  in  1  read strobe, sampled with ce
- sfr_din  in  8  write data
- sfr_dout  out  8  read data, registered
- NMI  out  1  NMI pending, to controller
- EXIC0, EXIC1, EXIC2  out  8 each  register contents, to controller
- NMI_clear, EXIC0_clear, EXIC1_clear, EXIC2_clear  in  1 each  one-clk acknowledge pulses from controller
- INTM_out  out  8  INTM contents

Behaviour:
- Reset values (async): EXICn=8'h47 (flag 0, mask 1, prio 7); INTM=8'h00; NMI=0; sfr_dout=0; synchronisers=0; prev-level=0.
- EXIC layout: [7] EXIF request, [6] EXMK mask, [5:3] stored, no function here, [2:0] priority.
- INTM layout: [0] NMI edge, [1]/[2]/[3] INTP0/1/2 edge; 1=rising, 0=falling. [7:4] read as 0.
- Pin path, per pin:
  - SYNC_STAGES-flop synchroniser on ce, then prev-level flop.
  - Trigger = (sync ^ prev) & (prev ^ dir).
  - Pin change to flag set: SYNC_STAGES+1 ce cycles (3 at default).
- Writing INTM re-arms nothing. prev is still updated, so a polarity change alone never fires.
- NMI latch: set on NMI trigger, cleared on NMI_clear. NMI cannot be masked here.
- EXIF bit 7 next-value priority, per register: trigger > clear pulse > SFR write.
  - An edge coinciding with a clear or a write leaves EXIF=1, so no request is lost.
  - Bits [6:0] take the SFR write unconditionally.
- SFR write: on ce & sfr_wr, the addressed register updates next clk. Unmapped addresses are ignored. Writing 1 to EXIF (software request) is allowed.
- SFR read: on ce & sfr_rd, sfr_dout <= addressed value next clk. Unmapped addresses return 8'h00. Without sfr_rd, sfr_dout holds.
  - A read in the same cycle as a write to the same address returns the old value.
- Clear pulses are honoured even when ce=0: each sets a sticky pending bit, applied at the next ce.
- A trigger while EXIF is already 1 is absorbed; there is no counting.
- Reset mid-operation drops all pending requests and synchroniser history. The first post-reset edge needs a full 0->1 or 1->0 transition seen after reset.

Optional Feature:
- Macro V35_INTP_FILTER_EN.
- When defined: each synchronised INTP/NMI level passes a noise filter before edge detection. The filtered level changes only after 4 consecutive identical ce samples that differ from it. Added latency: +3 ce cycles (6 total at default). Glitches shorter than 4 samples are dropped.
- When undefined: there is no filter, the filter counters are absent, and latency is SYNC_STAGES+1.

Decomposition:
- Shared package types:
  - SFR offset constants SFR_INTM, SFR_EXIC0..2.
  - EXIC bit-index constants EXIF_BIT=7, EXMK_BIT=6, EXPR_LSB=0.
  - EXIC_RESET=8'h47.
  - The packed struct for EXIC.
- One sub-module, v35_pin_detect (instantiated 4x), containing synchroniser, optional filter, prev flop, direction input and trigger output. It uses async reset, unlike the existing sync-reset edge helper.

Test Plan:
1. Reset check: assert reset mid-stream, then release. EXICn read 8'h47, INTM 8'h00, NMI=0, sfr_dout=0.
2. Rising INTP1: write INTM=8'h04, drive INTP1 0->1. EXIC1 goes 8'h47->8'hC7 exactly 3 ce cycles later; the INTP1 1->0 edge does not set it.
3. Falling NMI: INTM[0]=0, NMI_PIN 1->0. NMI=1 until an NMI_clear pulse, then 0 the next clk.
4. Collisions:
   - EXIC0_clear in the same clk as a new INTP0 trigger: EXIC0[7] stays 1.
   - SFR write 8'h05 to EXIC0 in the same clk as a trigger: EXIC0=8'h85.
5. ce gating: ce=1 every 3rd clk, EXIC2_clear pulsed on a ce=0 clk. Flag clears at the next ce clk. Pin latency scales to 3 ce cycles.
6. V35_INTP_FILTER_EN build: a 2-sample INTP0 glitch leaves EXIC0[7]=0; a 4-sample stable edge sets it 6 ce cycles after the change.
